multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
Sequencing controller for the shared iterative multiply/divide unit behind the processor's execute stage. It accepts one-cycle ctrl_MULT/ctrl_DIV pulses and latches the operands. It drives the datapath start/clear and counter_zero controls, counts the iterations, and returns a registered result with a one-cycle ready strobe. Divide-by-zero is short-circuited without running the datapath.

Parameters:
DIV_CYCLES, 32, number of iterate cycles the divider datapath needs after its load cycle
MULT_CYCLES, 16, number of iterate cycles the multiplier datapath needs after its load cycle
CNT_W, 6, counter width; must hold max(DIV_CYCLES, MULT_CYCLES)

Ports:
clock  in  1  single system clock, rising edge
resetn  in  1  asynchronous, active-low reset
ctrl_MULT  in  1  start multiply (one-cycle pulse)
ctrl_DIV  in  1  start divide (one-cycle pulse)
flush  in  1  cancel any operation in flight
data_operandA  in  32  operand A, sampled on the accept edge
data_operandB  in  32  operand B, sampled on the accept edge
dp_opA  out  32  latched operand A to the datapaths
dp_opB  out  32  latched operand B to the datapaths
dp_div_start  out  1  divider clear pulse (drives the divider's ctrl_DIV input)
dp_mult_start  out  1  multiplier clear pulse
dp_counter_zero  out  1  load-cycle indicator to the active datapath
div_result  in  32  divider datapath result
mult_result  in  32  multiplier datapath result
mult_ovf  in  1  multiplier overflow flag
busy  out  1  operation in flight
data_result  out  32  registered result
data_exception  out  1  registered exception (div by zero or mult overflow)
data_resultRDY  out  1  one-cycle result-valid strobe

Behaviour:
- States: IDLE, LOAD, RUN, DONE. 2-bit op register {NONE, MULT, DIV}. Down-counter cnt.
- Reset (resetn=0, asynchronous):
  - State goes to IDLE. op=NONE. cnt=0.
  - All outputs are 0, including dp_opA, dp_opB, data_result, data_exception and data_resultRDY.
  - Reset mid-operation aborts the operation with no RDY.
- Accepting an operation:
  - Acceptance happens only in IDLE or DONE, on an edge where ctrl_MULT or ctrl_DIV is 1.
  - On accept, latch data_operandA/data_operandB into dp_opA/dp_opB and set op.
  - If ctrl_MULT and ctrl_DIV are both 1, MULT wins and DIV is dropped.
  - Start pulses arriving in LOAD or RUN are ignored: no queueing, no restart.
- Divide by zero: on a DIV accept with data_operandB==0, go straight to DONE. In DONE: data_result=0, data_exception=1. No dp_div_start pulse.
- LOAD (1 cycle):
  - dp_counter_zero=1.
  - dp_div_start=1 if op=DIV; dp_mult_start=1 if op=MULT.
  - cnt is loaded with DIV_CYCLES or MULT_CYCLES.
- RUN:
  - dp_counter_zero=0. cnt decrements every cycle.
  - Exit to DONE on the edge where cnt==1.
  - RUN therefore lasts exactly DIV_CYCLES or MULT_CYCLES cycles.
- Result capture, on the edge RUN->DONE:
  - data_result is loaded with div_result or mult_result, selected by op.
  - data_exception is loaded with mult_ovf for MULT, 0 for DIV.
- DONE (1 cycle):
  - data_resultRDY=1.
  - Next state is LOAD if a new operation is accepted this cycle (back-to-back), or DIV-by-zero DONE again; otherwise IDLE.
- Result hold: data_result and data_exception hold their value until the next capture. They are not cleared on accept.
- busy = 1 in LOAD and RUN; 0 in IDLE and DONE.
- Latency, counting the accept edge as edge 0:
  - RDY is high in the cycle after edge N+1, with N=DIV_CYCLES or MULT_CYCLES.
  - DIV with default parameters: RDY after edge 33.
  - Div-by-zero: RDY in the cycle after edge 0.
- flush (synchronous, highest priority after reset):
  - Forces IDLE, op=NONE, cnt=0. No RDY is generated.
  - data_result and data_exception are unchanged.
  - A start pulse coincident with flush is dropped.
- Invariants:
  - dp_div_start and dp_mult_start are never both 1.
  - data_resultRDY is never high for two consecutive cycles unless a back-to-back div-by-zero occurs.

Test Plan:
- DIV A=100, B=7 (datapath model returns remainder 2) -> busy high for 33 cycles; RDY after edge 33 for exactly one cycle; data_result=2; data_exception=0.
- DIV A=5, B=0 -> RDY in the cycle after the accept edge; data_result=0; data_exception=1; dp_div_start never asserted.
- MULT A=3, B=4 with mult_result=12 and mult_ovf=0 -> RDY after edge 17; data_result=12. Repeat with mult_ovf=1 -> data_exception=1.
- Back-to-back ops:
  - ctrl_DIV pulsed during RUN of a MULT -> ignored; only the MULT result is returned.
  - ctrl_DIV pulsed in the DONE cycle -> LOAD follows immediately; second RDY after a further 33 edges.
  - ctrl_MULT=ctrl_DIV=1 in IDLE -> MULT is performed.
- flush at RUN cycle 10 -> IDLE next cycle; no RDY; previous data_result retained. resetn=0 mid-RUN -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/multdiv_ctrl_if.sv
// Signal bundle between the execute stage, the multdiv sequencer and the iterative datapaths.
interface multdiv_ctrl_if;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic        flush;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] dp_opA;
    logic [31:0] dp_opB;
    logic        dp_div_start;
    logic        dp_mult_start;
    logic        dp_counter_zero;
    logic [31:0] div_result;
    logic [31:0] mult_result;
    logic        mult_ovf;
    logic        busy;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;

    modport slave (
        input  ctrl_MULT, ctrl_DIV, flush, data_operandA, data_operandB,
               div_result, mult_result, mult_ovf,
        output dp_opA, dp_opB, dp_div_start, dp_mult_start, dp_counter_zero,
               busy, data_result, data_exception, data_resultRDY
    );

    modport master (
        output ctrl_MULT, ctrl_DIV, flush, data_operandA, data_operandB,
               div_result, mult_result, mult_ovf,
        input  dp_opA, dp_opB, dp_div_start, dp_mult_start, dp_counter_zero,
               busy, data_result, data_exception, data_resultRDY
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared iterative multiply/divide datapath: accept, load, iterate,
// capture result. Divide-by-zero bypasses the datapath entirely.
module multdiv_ctrl #(
    parameter int DIV_CYCLES  = 32,
    parameter int MULT_CYCLES = 16,
    parameter int CNT_W       = 6
) (
    input  logic          clock,
    input  logic          resetn,
    multdiv_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
    typedef enum logic [1:0] {OP_NONE, OP_MULT, OP_DIV} op_t;

    state_t             state;
    op_t                op;
    logic [CNT_W-1:0]   cnt;
    logic               start;

    assign start = (state == IDLE || state == DONE) && (bus.ctrl_MULT || bus.ctrl_DIV);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state               <= IDLE;
            op                  <= OP_NONE;
            cnt                 <= '0;
            bus.dp_opA          <= '0;
            bus.dp_opB          <= '0;
            bus.dp_div_start    <= 1'b0;
            bus.dp_mult_start   <= 1'b0;
            bus.dp_counter_zero <= 1'b0;
            bus.busy            <= 1'b0;
            bus.data_result     <= '0;
            bus.data_exception  <= 1'b0;
            bus.data_resultRDY  <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            bus.dp_div_start    <= 1'b0;
            bus.dp_mult_start   <= 1'b0;
            bus.dp_counter_zero <= 1'b0;
            bus.data_resultRDY  <= 1'b0;
            if (bus.flush) begin
                state    <= IDLE;
                op       <= OP_NONE;
                cnt      <= '0;
                bus.busy <= 1'b0;
            end else begin
                case (state)
                    IDLE, DONE: begin
                        if (start) begin
                            bus.dp_opA <= bus.data_operandA;
                            bus.dp_opB <= bus.data_operandB;
                            if (bus.ctrl_MULT) begin
                                op                  <= OP_MULT;
                                state               <= LOAD;
                                bus.dp_mult_start   <= 1'b1;
                                bus.dp_counter_zero <= 1'b1;
                                bus.busy            <= 1'b1;
                            end else if (bus.data_operandB == 32'd0) begin
                                op                 <= OP_DIV;
                                state              <= DONE;
                                bus.data_result    <= '0;
                                bus.data_exception <= 1'b1;
                                bus.data_resultRDY <= 1'b1;
                                bus.busy           <= 1'b0;
                            end else begin
                                op                  <= OP_DIV;
                                state               <= LOAD;
                                bus.dp_div_start    <= 1'b1;
                                bus.dp_counter_zero <= 1'b1;
                                bus.busy            <= 1'b1;
                            end
                        end else begin
                            state    <= IDLE;
                            op       <= OP_NONE;
                            bus.busy <= 1'b0;
                        end
                    end
                    LOAD: begin
                        cnt      <= (op == OP_DIV) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state    <= RUN;
                        bus.busy <= 1'b1;
                    end
                    RUN: begin
                        if (cnt == CNT_W'(1)) begin
                            cnt                <= '0;
                            state              <= DONE;
                            bus.busy           <= 1'b0;
                            bus.data_resultRDY <= 1'b1;
                            if (op == OP_DIV) begin
                                bus.data_result    <= bus.div_result;
                                bus.data_exception <= 1'b0;
                            end else begin
                                bus.data_result    <= bus.mult_result;
                                bus.data_exception <= bus.mult_ovf;
                            end
                        end else begin
                            cnt      <= cnt - CNT_W'(1);
                            bus.busy <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        op       <= OP_NONE;
                        bus.busy <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: stimulus pushes expected results with their due cycle,
// a negedge monitor pops and compares whenever a result strobe appears.
module tb_multdiv_ctrl;
    localparam int DIVC  = 32;
    localparam int MULTC = 16;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          due;
    } exp_t;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    multdiv_ctrl_if bus ();
    multdiv_ctrl #(.DIV_CYCLES(DIVC), .MULT_CYCLES(MULTC), .CNT_W(6)) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    // Stand-in datapaths: ideal combinational multiplier and divider on the latched operands.
    logic        ovf_force = 1'b0;
    logic [63:0] prod;
    assign prod            = {32'd0, bus.dp_opA} * {32'd0, bus.dp_opB};
    assign bus.mult_result = prod[31:0];
    assign bus.mult_ovf    = (prod[63:32] != 32'd0) | ovf_force;
    assign bus.div_result  = (bus.dp_opB == 32'd0) ? 32'd0 : bus.dp_opA % bus.dp_opB;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          busy_cnt = 0;
    int          div_start_cnt = 0;
    logic [31:0] last_res = 32'd0;
    logic        last_exc = 1'b0;
    exp_t        sb[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clock) begin
        if (resetn) begin
            check("start_exclusive", 32'(bus.dp_div_start & bus.dp_mult_start), 32'd0);
            if (bus.busy) busy_cnt++;
            if (bus.dp_div_start) div_start_cnt++;
            if (bus.data_resultRDY) begin
                if (sb.size() == 0) begin
                    check("rdy_without_pending_op", 32'(sb.size()), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data_result", bus.data_result, e.res);
                    check("data_exception", 32'(bus.data_exception), 32'(e.exc));
                    check("rdy_cycle", 32'(cyc), 32'(e.due));
                    last_res = e.res;
                    last_exc = e.exc;
                end
            end
        end
    end

    // Called at posedge+1; drives a one-cycle start pulse and records the expected outcome.
    task automatic issue(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b,
                         input bit f, input bit expect_rdy);
        exp_t        e;
        logic [63:0] p;
        int          accept_edge;
        accept_edge           = cyc + 1;
        ovf_force             = f;
        bus.ctrl_MULT         = m;
        bus.ctrl_DIV          = d;
        bus.data_operandA     = a;
        bus.data_operandB     = b;
        if (m) begin
            p     = {32'd0, a} * {32'd0, b};
            e.res = p[31:0];
            e.exc = (p[63:32] != 32'd0) || f;
            e.due = accept_edge + MULTC + 1;
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.due = accept_edge;
        end else begin
            e.res = a % b;
            e.exc = 1'b0;
            e.due = accept_edge + DIVC + 1;
        end
        if (expect_rdy && (m || d)) sb.push_back(e);
        @(posedge clock); #1;
        bus.ctrl_MULT     = 1'b0;
        bus.ctrl_DIV      = 1'b0;
        bus.data_operandA = $urandom;
        bus.data_operandB = $urandom;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (sb.size() != 0 && t < 300) begin
            @(posedge clock); #1;
            t++;
        end
        if (sb.size() != 0) begin
            check("wait_timeout_pending", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clock); #1;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_rdy"}, 32'(bus.data_resultRDY), 32'd0);
        check({tag, "_result"}, bus.data_result, 32'd0);
        check({tag, "_exception"}, 32'(bus.data_exception), 32'd0);
        check({tag, "_opA"}, bus.dp_opA, 32'd0);
        check({tag, "_opB"}, bus.dp_opB, 32'd0);
        check({tag, "_starts"}, 32'({bus.dp_div_start, bus.dp_mult_start, bus.dp_counter_zero}), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "simulation timed out");
    end

    initial begin
        bus.ctrl_MULT = 1'b0; bus.ctrl_DIV = 1'b0; bus.flush = 1'b0;
        bus.data_operandA = 32'd0; bus.data_operandB = 32'd0;
        #1;
        check_all_zero("reset");
        idle_cycles(2);
        resetn = 1'b1;
        idle_cycles(2);

        // Divide with remainder result; busy spans load plus all iterations.
        busy_cnt = 0;
        issue(0, 1, 32'd100, 32'd7, 0, 1);
        wait_idle();
        check("div_busy_cycles", 32'(busy_cnt), 32'(DIVC + 1));

        // Divide by zero: immediate result, datapath never started.
        busy_cnt = 0; div_start_cnt = 0;
        issue(0, 1, 32'd5, 32'd0, 0, 1);
        wait_idle();
        check("div0_no_div_start", 32'(div_start_cnt), 32'd0);
        check("div0_no_busy", 32'(busy_cnt), 32'd0);

        // Multiply without and with overflow.
        busy_cnt = 0;
        issue(1, 0, 32'd3, 32'd4, 0, 1);
        wait_idle();
        check("mult_busy_cycles", 32'(busy_cnt), 32'(MULTC + 1));
        issue(1, 0, 32'd3, 32'd4, 1, 1);
        wait_idle();

        // Divide start during a multiply's RUN is ignored.
        issue(1, 0, 32'd9, 32'd11, 0, 1);
        idle_cycles(5);
        issue(0, 1, 32'd50, 32'd3, 0, 0);
        wait_idle();
        idle_cycles(40);

        // Back-to-back: second divide accepted in the DONE cycle of the first.
        issue(0, 1, 32'd1000, 32'd33, 0, 1);
        begin
            int t = 0;
            while (!bus.data_resultRDY && t < 100) begin
                @(posedge clock); #1;
                t++;
            end
            check("b2b_first_rdy_seen", 32'(bus.data_resultRDY), 32'd1);
        end
        issue(0, 1, 32'd77, 32'd10, 0, 1);
        wait_idle();

        // Back-to-back divide-by-zero from DONE of another divide-by-zero.
        issue(0, 1, 32'd1, 32'd0, 0, 1);
        issue(0, 1, 32'd2, 32'd0, 0, 1);
        wait_idle();

        // Simultaneous starts: multiply wins.
        issue(1, 1, 32'd6, 32'd7, 0, 1);
        wait_idle();

        // Flush at RUN cycle 10: no result, previous result retained.
        issue(0, 1, 32'd500, 32'd9, 0, 0);
        idle_cycles(10);
        bus.flush = 1'b1;
        @(posedge clock); #1;
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_result_kept", bus.data_result, last_res);
        check("flush_exception_kept", 32'(bus.data_exception), 32'(last_exc));
        idle_cycles(40);

        // Start coincident with flush is dropped.
        bus.flush = 1'b1;
        issue(1, 0, 32'd2, 32'd2, 0, 0);
        bus.flush = 1'b0;
        idle_cycles(3);
        check("flush_start_dropped", 32'(bus.busy), 32'd0);
        idle_cycles(25);

        // Asynchronous reset mid-RUN clears everything without a clock edge.
        issue(1, 0, 32'd123, 32'd456, 0, 0);
        idle_cycles(8);
        #2;
        resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        last_res = 32'd0; last_exc = 1'b0;
        @(posedge clock); #1;
        resetn = 1'b1;
        idle_cycles(2);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            bit          m;
            bit          f;
            logic [31:0] a;
            logic [31:0] b;
            m = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 65535)) : $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            issue(m, !m, a, b, f, 1);
            wait_idle();
        end

        idle_cycles(5);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
